// File: rtl/ibex_tb_pkg.sv
// ibex_tb_pkg: shared constants and response payload type for the instruction memory responder.
package ibex_tb_pkg;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } instr_resp_t;
endpackage

// File: rtl/ibex_instr_resp_pipe.sv
// ibex_instr_resp_pipe: fixed-latency valid/payload shift register with async clear.
module ibex_instr_resp_pipe
  import ibex_tb_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  instr_resp_t in_data,
  output logic        out_valid,
  output instr_resp_t out_data
);
  logic [LATENCY-1:0] valid;
  instr_resp_t        data [LATENCY];
  // Empty slots carry a zero payload so the output needs no extra gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < LATENCY; i++) data[i] <= '0;
    end else begin
      valid[0] <= in_valid;
      data[0]  <= in_valid ? in_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid[i] <= valid[i-1];
        data[i]  <= data[i-1];
      end
    end
  end
  assign out_valid = valid[LATENCY-1];
  assign out_data  = data[LATENCY-1];
endmodule

// File: rtl/ibex_instr_mem_responder.sv
// ibex_instr_mem_responder: instruction memory model with fixed latency and bounded outstanding requests.
// INSTR_MEM_ERR_INJ_EN: out-of-range fetches respond with err=1 and rdata=0.
module ibex_instr_mem_responder
  import ibex_tb_pkg::*;
#(
  parameter int MEM_DEPTH       = 8,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic [6:0]    instr_rdata_intg_o,
  output logic          instr_err_o,
  input  logic          stall_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [31:0]   prog_wdata_i,
  output logic [OW-1:0] outstanding_o,
  output logic [31:0]   resp_cnt_o
);
  logic [31:0]   mem [MEM_DEPTH];
  logic [AW-1:0] idx;
  logic          unused_addr;
  instr_resp_t   req_resp, out_resp;
  assign idx         = instr_addr_i[AW+1:2];
  assign unused_addr = ^{instr_addr_i[31:AW+2], instr_addr_i[1:0]};
  assign instr_gnt_o = instr_req_i & ~stall_i & ~rst_i & (outstanding_o < OW'(MAX_OUTSTANDING));
`ifdef INSTR_MEM_ERR_INJ_EN
  always_comb begin
    req_resp.err   = |instr_addr_i[31:AW+2];
    req_resp.rdata = req_resp.err ? '0 : mem[idx];
  end
`else
  always_comb begin
    req_resp.err   = 1'b0;
    req_resp.rdata = mem[idx];
  end
`endif
  // Read happens before the same-edge write lands, so a colliding fetch sees the old word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= NOP_INSN;
    else if (prog_we_i) mem[prog_addr_i] <= prog_wdata_i;
  end
  ibex_instr_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (instr_gnt_o),
    .in_data   (req_resp),
    .out_valid (instr_rvalid_o),
    .out_data  (out_resp)
  );
  assign instr_rdata_o      = out_resp.rdata;
  assign instr_err_o        = out_resp.err;
  assign instr_rdata_intg_o = 7'h0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_o <= '0;
      resp_cnt_o    <= '0;
    end else begin
      outstanding_o <= outstanding_o + OW'(instr_gnt_o) - OW'(instr_rvalid_o);
      resp_cnt_o    <= resp_cnt_o + 32'(instr_rvalid_o);
    end
  end
endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// tb_ibex_instr_mem_responder: directed vector table, reset sequence and random traffic against a queue model.
module tb_ibex_instr_mem_responder;
  import ibex_tb_pkg::*;
  localparam int D = 8;
  localparam int L = 3;
  localparam int M = 2;

  logic        clk_i = 0, rst_i = 1;
  logic        instr_req_i = 0, stall_i = 0, prog_we_i = 0;
  logic [31:0] instr_addr_i = 0, prog_wdata_i = 0;
  logic [2:0]  prog_addr_i = 0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o, resp_cnt_o;
  logic [6:0]  instr_rdata_intg_o;
  logic [1:0]  outstanding_o;

  ibex_instr_mem_responder #(.MEM_DEPTH(D), .LATENCY(L), .MAX_OUTSTANDING(M)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .instr_rdata_intg_o(instr_rdata_intg_o), .instr_err_o(instr_err_o), .stall_i(stall_i),
    .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_wdata_i(prog_wdata_i),
    .outstanding_o(outstanding_o), .resp_cnt_o(resp_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  a_out_bound: assert property (@(posedge clk_i) disable iff (rst_i) outstanding_o <= 2'(M))
    else $error("outstanding_o exceeded bound");

  typedef struct {int due; logic [31:0] rdata; logic err;} pend_t;
  typedef struct {
    logic req; logic [31:0] addr; logic stall, we; logic [2:0] paddr; logic [31:0] wdata;
    logic gnt, rv; logic [31:0] rdata; logic err;
  } vec_t;

  pend_t       q[$];
  logic [31:0] mem_m [D];
  logic [31:0] cnt_m;
  int          cyc, checks, failures;

`ifdef INSTR_MEM_ERR_INJ_EN
  localparam logic [31:0] R100 = 32'h0;
  localparam logic        E100 = 1'b1;
`else
  localparam logic [31:0] R100 = 32'h00A00093;
  localparam logic        E100 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t v(logic req, logic [31:0] addr, logic stall, logic we, logic [2:0] paddr,
                             logic [31:0] wdata, logic gnt, logic rv, logic [31:0] rdata, logic err);
    v = '{req, addr, stall, we, paddr, wdata, gnt, rv, rdata, err};
  endfunction

  // Called at posedge+1; compares at the falling edge, then advances the model across the next posedge.
  task automatic step(input logic req, input logic [31:0] addr, input logic stall, input logic we,
                      input logic [2:0] paddr, input logic [31:0] wdata,
                      output logic g, output logic rv, output logic [31:0] rd, output logic er);
    logic        exp_rv, exp_g, bad;
    logic [31:0] exp_rd;
    logic        exp_er;
    instr_req_i = req; instr_addr_i = addr; stall_i = stall;
    prog_we_i = we; prog_addr_i = paddr; prog_wdata_i = wdata;
    #4;
    exp_rv = q.size() > 0 && q[0].due == cyc;
    exp_rd = exp_rv ? q[0].rdata : 32'h0;
    exp_er = exp_rv ? q[0].err : 1'b0;
    exp_g  = req && !stall && q.size() < M;
    check("gnt", 32'(instr_gnt_o), 32'(exp_g));
    check("rvalid", 32'(instr_rvalid_o), 32'(exp_rv));
    check("rdata", instr_rdata_o, exp_rd);
    check("err", 32'(instr_err_o), 32'(exp_er));
    check("outstanding", 32'(outstanding_o), 32'(q.size()));
    check("resp_cnt", resp_cnt_o, cnt_m);
    check("rdata_intg", 32'(instr_rdata_intg_o), 32'h0);
    g = instr_gnt_o; rv = instr_rvalid_o; rd = instr_rdata_o; er = instr_err_o;
    if (exp_rv) begin
      void'(q.pop_front());
      cnt_m++;
    end
    if (exp_g) begin
`ifdef INSTR_MEM_ERR_INJ_EN
      bad = addr[31:5] != 0;
`else
      bad = 1'b0;
`endif
      q.push_back('{cyc + L, bad ? 32'h0 : mem_m[addr[4:2]], bad});
    end
    if (we) mem_m[paddr] = wdata;
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_i = 1; instr_req_i = 1; stall_i = 0; prog_we_i = 0;
    #1;
    check("rst_gnt", 32'(instr_gnt_o), 32'h0);
    check("rst_rvalid", 32'(instr_rvalid_o), 32'h0);
    check("rst_rdata", instr_rdata_o, 32'h0);
    check("rst_err", 32'(instr_err_o), 32'h0);
    check("rst_outstanding", 32'(outstanding_o), 32'h0);
    check("rst_resp_cnt", resp_cnt_o, 32'h0);
    q.delete();
    for (int i = 0; i < D; i++) mem_m[i] = NOP_INSN;
    cnt_m = 0;
    instr_req_i = 0;
    @(posedge clk_i);
    #1;
    cyc++;
    rst_i = 0;
  endtask

  vec_t        tbl [25];
  logic        g, rv, er;
  logic [31:0] rd;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    tbl[0]  = v(1, 32'h0,   0, 0, 0, 0,            1, 0, 32'h0,        0);
    tbl[1]  = v(0, 32'h0,   0, 1, 7, 32'h3B169073, 0, 0, 32'h0,        0);
    tbl[2]  = v(0, 32'h0,   0, 0, 0, 0,            0, 0, 32'h0,        0);
    tbl[3]  = v(0, 32'h0,   0, 0, 0, 0,            0, 1, NOP_INSN,     0);
    tbl[4]  = v(1, 32'h1C,  0, 0, 0, 0,            1, 0, 32'h0,        0);
    tbl[5]  = v(1, 32'h1C,  0, 1, 7, 32'hDEADBEEF, 1, 0, 32'h0,        0);
    tbl[6]  = v(1, 32'h1C,  0, 0, 0, 0,            0, 0, 32'h0,        0);
    tbl[7]  = v(1, 32'h1C,  0, 0, 0, 0,            0, 1, 32'h3B169073, 0);
    tbl[8]  = v(1, 32'h1C,  0, 0, 0, 0,            1, 1, 32'h3B169073, 0);
    tbl[9]  = v(1, 32'h1C,  0, 0, 0, 0,            1, 0, 32'h0,        0);
    tbl[10] = v(0, 32'h0,   0, 0, 0, 0,            0, 0, 32'h0,        0);
    tbl[11] = v(0, 32'h0,   0, 0, 0, 0,            0, 1, 32'hDEADBEEF, 0);
    tbl[12] = v(0, 32'h0,   0, 0, 0, 0,            0, 1, 32'hDEADBEEF, 0);
    tbl[13] = v(1, 32'h0,   1, 1, 0, 32'h00A00093, 0, 0, 32'h0,        0);
    tbl[14] = v(1, 32'h0,   1, 0, 0, 0,            0, 0, 32'h0,        0);
    tbl[15] = v(1, 32'h0,   1, 0, 0, 0,            0, 0, 32'h0,        0);
    tbl[16] = v(1, 32'h0,   1, 0, 0, 0,            0, 0, 32'h0,        0);
    tbl[17] = v(1, 32'h0,   0, 0, 0, 0,            1, 0, 32'h0,        0);
    tbl[18] = v(0, 32'h0,   0, 0, 0, 0,            0, 0, 32'h0,        0);
    tbl[19] = v(0, 32'h0,   0, 0, 0, 0,            0, 0, 32'h0,        0);
    tbl[20] = v(0, 32'h0,   0, 0, 0, 0,            0, 1, 32'h00A00093, 0);
    tbl[21] = v(1, 32'h100, 0, 0, 0, 0,            1, 0, 32'h0,        0);
    tbl[22] = v(0, 32'h0,   0, 0, 0, 0,            0, 0, 32'h0,        0);
    tbl[23] = v(0, 32'h0,   0, 0, 0, 0,            0, 0, 32'h0,        0);
    tbl[24] = v(0, 32'h0,   0, 0, 0, 0,            0, 1, R100,         E100);
    @(posedge clk_i);
    #1;
    do_reset();
    cyc = 0;
    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].addr, tbl[i].stall, tbl[i].we, tbl[i].paddr, tbl[i].wdata, g, rv, rd, er);
      check($sformatf("tbl%0d_gnt", i), 32'(g), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_rvalid", i), 32'(rv), 32'(tbl[i].rv));
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
      check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].err));
    end
    // Reset one cycle after a grant must drop the in-flight response and restore NOPs.
    step(1, 32'h1C, 0, 0, 0, 0, g, rv, rd, er);
    check("pre_rst_gnt", 32'(g), 32'h1);
    do_reset();
    for (int i = 0; i < L + 2; i++) begin
      step(0, 32'h0, 0, 0, 0, 0, g, rv, rd, er);
      check("post_rst_no_rvalid", 32'(rv), 32'h0);
    end
    for (int i = 0; i < D; i++) begin
      step(1, 32'(i * 4), 0, 0, 0, 0, g, rv, rd, er);
      for (int k = 0; k < L; k++) step(0, 32'h0, 0, 0, 0, 0, g, rv, rd, er);
      check($sformatf("nop_idx%0d", i), rd, NOP_INSN);
    end
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
           3'($urandom_range(0, 7)), $urandom, g, rv, rd, er);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
